// File: rtl/apu_wave_pkg.sv
// Shared types and sizes for the APU wave RAM path.
package apu_wave_pkg;

    localparam int WAVE_BYTES = 16;
    localparam int WAVE_AW    = 4;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD
    } wave_arb_state_t;

    typedef enum logic {
        OWN_CPU,
        OWN_CH3
    } wave_owner_t;

    // Wraps 15 -> 0 through natural overflow of the address width.
    function automatic logic [WAVE_AW-1:0] wave_ptr_inc(input logic [WAVE_AW-1:0] p);
        return p + 1'b1;
    endfunction

endpackage

// File: rtl/wave_ram_arbiter.sv
// Shares the 16x8 wave RAM between CPU register accesses and channel 3 sample
// fetches; owns the RAM strobes and the channel 3 byte pointer.
module wave_ram_arbiter
    import apu_wave_pkg::*;
#(
    parameter int STROBE_LEN = 2,   // 1..4 cycles of active OE/WR
    parameter bit DMG_QUIRK  = 1'b1
) (
    input  logic               clk,
    input  logic               nreset,
    input  logic               cpu_req,
    input  logic               cpu_we,
    input  logic [WAVE_AW-1:0] cpu_addr,
    input  logic [7:0]         cpu_wdata,
    output logic               cpu_ack,
    output logic [7:0]         cpu_rdata,
    input  logic               ch3_req,
    input  logic               ch3_restart,
    input  logic               ch3_active,
    output logic               ch3_ack,
    output logic [7:0]         ch3_data,
    output logic [WAVE_AW-1:0] ch3_ptr,
    output logic               ch3_overrun,
    output logic [WAVE_AW-1:0] wave_a,
    output logic               wave_ram_ctrl1,
    output logic               nwave_ram_wr,
    output logic               atok,
    input  logic [7:0]         wave_rd_d,
    input  logic [7:0]         d
);

    localparam logic [1:0] STROBE_LAST = 2'(STROBE_LEN - 1);

    wave_arb_state_t    state, state_nxt;
    wave_owner_t        owner, owner_nxt;
    logic               acc_we, acc_we_nxt;
    logic [WAVE_AW-1:0] addr_nxt;
    logic [1:0]         strobe_cnt, strobe_cnt_nxt;
    logic               pending, pending_live;
    logic               grant_ch3, strobe_done;
    logic               cpu_use_ptr;

    // Write data reaches the RAM through the top-level bus, not through this block.
    logic unused_bus;
    assign unused_bus = ^{d, cpu_wdata};

    assign pending_live = pending & ~ch3_restart;
    assign cpu_use_ptr  = DMG_QUIRK && ch3_active;

    // The owner register doubles as "previous owner" while idle, which is what
    // the alternation rule looks at.
    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        acc_we_nxt     = acc_we;
        addr_nxt       = wave_a;
        strobe_cnt_nxt = strobe_cnt;
        grant_ch3      = 1'b0;
        strobe_done    = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_req && (owner == OWN_CH3 || !pending_live)) begin
                    state_nxt  = SETUP;
                    owner_nxt  = OWN_CPU;
                    acc_we_nxt = cpu_we;
                    addr_nxt   = cpu_use_ptr ? ch3_ptr : cpu_addr;
                end else if (pending_live) begin
                    state_nxt  = SETUP;
                    owner_nxt  = OWN_CH3;
                    acc_we_nxt = 1'b0;
                    addr_nxt   = ch3_ptr;
                    grant_ch3  = 1'b1;
                end
            end
            SETUP: begin
                state_nxt      = STROBE;
                strobe_cnt_nxt = 2'd0;
            end
            STROBE: begin
                if (strobe_cnt == STROBE_LAST) begin
                    state_nxt   = HOLD;
                    strobe_done = 1'b1;
                end else begin
                    strobe_cnt_nxt = strobe_cnt + 2'd1;
                end
            end
            HOLD: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Strobes and acks are registered from the next state so they are glitch-free
    // and drop asynchronously with reset.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state          <= IDLE;
            owner          <= OWN_CPU;
            acc_we         <= 1'b0;
            strobe_cnt     <= 2'd0;
            wave_a         <= '0;
            wave_ram_ctrl1 <= 1'b1;
            nwave_ram_wr   <= 1'b1;
            atok           <= 1'b1;
            cpu_ack        <= 1'b0;
            ch3_ack        <= 1'b0;
        end else begin
            state          <= state_nxt;
            owner          <= owner_nxt;
            acc_we         <= acc_we_nxt;
            strobe_cnt     <= strobe_cnt_nxt;
            wave_a         <= addr_nxt;
            wave_ram_ctrl1 <= (state_nxt == IDLE);
            atok           <= !(state_nxt == STROBE && !acc_we_nxt);
            nwave_ram_wr   <= !(state_nxt == STROBE && acc_we_nxt);
            cpu_ack        <= (state_nxt == HOLD) && (owner_nxt == OWN_CPU);
            ch3_ack        <= (state_nxt == HOLD) && (owner_nxt == OWN_CH3);
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            pending     <= 1'b0;
            ch3_overrun <= 1'b0;
            ch3_ptr     <= '0;
            cpu_rdata   <= 8'hFF;
            ch3_data    <= 8'h00;
        end else begin
            // A request landing on the grant edge becomes the next pending fetch.
            if (ch3_restart)
                pending <= 1'b0;
            else if (grant_ch3)
                pending <= ch3_req;
            else if (ch3_req)
                pending <= 1'b1;

            ch3_overrun <= ch3_req && pending && !grant_ch3 && !ch3_restart;

            if (ch3_restart)
                ch3_ptr <= '0;
            else if (strobe_done && owner == OWN_CH3)
                ch3_ptr <= wave_ptr_inc(ch3_ptr);

            if (strobe_done) begin
                if (owner == OWN_CH3)
                    ch3_data <= wave_rd_d;
                else if (!acc_we)
                    cpu_rdata <= wave_rd_d;
            end
        end
    end

endmodule
